mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency memory port between instruction fetch and load/store.
// Data wins ties unless fetch has been passed over MAX_STARVE times in a row.
//
// state | meaning
// IDLE  | arbitrate pending requests, latch attributes of the winner
// FETCH | fetch access in flight, waiting for i_mem_ready or timeout
// DATA  | load/store access in flight, waiting for i_mem_ready or timeout
// RESP  | ack (and err) pulse to the owner; requests not sampled
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16,
  parameter int MAX_STARVE = 3
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_b,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ack,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic [3:0]        i_d_be,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_ack,
  output logic              o_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic              o_core_stall
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_RESP} state_t;

  state_t              r_state;
  logic [SW-1:0]       r_starve_cnt;
  logic [WW-1:0]       r_wait_cnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [3:0]          r_mem_be;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_if_ack;
  logic                r_d_ack;
  logic                r_err;

  logic w_grant_fetch;
  logic w_grant_data;
  logic w_done;

  assign w_grant_fetch = i_if_req & (~i_d_req | (r_starve_cnt == STARVE_MAX));
  assign w_grant_data  = i_d_req & ~w_grant_fetch;
  // a ready in the last wait cycle wins over the timeout
  assign w_done        = i_mem_ready | (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_b) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_wait_cnt   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wait_cnt <= '0;
          if (w_grant_fetch) begin
            r_state      <= S_FETCH;
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= i_if_addr;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_starve_cnt <= '0;
          end else if (w_grant_data) begin
            r_state     <= S_DATA;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_d_we;
            r_mem_addr  <= i_d_addr;
            r_mem_wdata <= i_d_wdata;
            r_mem_be    <= i_d_be;
            if (!i_if_req)
              r_starve_cnt <= '0;
            else if (r_starve_cnt != STARVE_MAX)
              r_starve_cnt <= r_starve_cnt + SW'(1);
          end
        end
        S_FETCH, S_DATA: begin
          if (w_done) begin
            r_mem_req <= 1'b0;
            r_state   <= S_RESP;
            r_err     <= ~i_mem_ready;
            if (r_state == S_FETCH) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= i_mem_ready ? i_mem_rdata : '0;
            end else begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= (i_mem_ready && !r_mem_we) ? i_mem_rdata : '0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_be     = r_mem_be;
  assign o_if_rdata   = r_if_rdata;
  assign o_d_rdata    = r_d_rdata;
  assign o_if_ack     = r_if_ack;
  assign o_d_ack      = r_d_ack;
  assign o_err        = r_err;
  assign o_core_stall = (i_if_req & ~r_if_ack) | (i_d_req & ~r_d_ack);

endmodule
